// File: rtl/led_frame_streamer_if.sv
// Bus between the frame streamer and its surroundings: the frame buffer read port, the
// LED driver chain pins and the animator handshake. The master modport is the streamer side.
interface led_frame_streamer_if #(
  parameter int c_addr_w = 10,
  parameter int c_bpc    = 12
);
  logic                i_en;
  logic [c_addr_w-1:0] o_addr;
  logic [c_bpc-1:0]    i_data;
  logic                o_sclk;
  logic                o_sdata;
  logic                o_latch;
  logic                o_drq;
  logic                o_busy;

  modport master (
    input  i_en, i_data,
    output o_addr, o_sclk, o_sdata, o_latch, o_drq, o_busy
  );

  modport slave (
    output i_en, i_data,
    input  o_addr, o_sclk, o_sdata, o_latch, o_drq, o_busy
  );
endinterface

// File: rtl/led_frame_streamer.sv
// Scans the frame buffer from the highest channel down to 0, shifts each value MSB-first onto
// the LED driver chain, strobes latch, then pulses o_drq to ask the animator for the next frame.
module led_frame_streamer #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = 12,
  parameter int c_div       = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  led_frame_streamer_if.master   bus
);

  localparam int c_bit_w = $clog2(c_bpc);
  localparam int c_div_w = $clog2(c_div) + 1;

  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
  localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(c_bpc - 1);
  localparam logic [c_div_w-1:0]  c_div_max   = c_div_w'(c_div - 1);

  typedef enum logic [2:0] {
    s_idle,
    s_fetch,
    s_load,
    s_shift,
    s_latch,
    s_done
  } state_t;

  state_t              state_q,   state_d;
  logic [c_addr_w-1:0] addr_q,    addr_d;
  logic [c_bpc-1:0]    shreg_q,   shreg_d;
  logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;
  logic [c_div_w-1:0]  div_cnt_q, div_cnt_d;
  logic                sclk_q,    sclk_d;
  logic                sdata_q,   sdata_d;
  logic                latch_q,   latch_d;
  logic                drq_q,     drq_d;
  logic                busy_q,    busy_d;

  always_comb begin
    // NOTE: every value gets a default first so no path through the case leaves it unassigned;
    // otherwise synthesis would infer a latch to hold the old value.
    state_d   = state_q;
    addr_d    = addr_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    drq_d     = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      s_idle: begin
        if (bus.i_en) begin
          addr_d  = c_last_addr;
          busy_d  = 1'b1;
          state_d = s_fetch;
        end
      end

      // The RAM samples o_addr during this cycle; its data appears in s_load.
      s_fetch: state_d = s_load;

      s_load: begin
        shreg_d   = bus.i_data;
        bit_cnt_d = c_last_bit;
        sdata_d   = bus.i_data[c_bpc-1];
        div_cnt_d = '0;
        sclk_d    = 1'b0;
        state_d   = s_shift;
      end

      s_shift: begin
        if (div_cnt_q != c_div_max) begin
          div_cnt_d = div_cnt_q + c_div_w'(1);
        end else begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a high phase: the next bit is presented together with the falling edge.
            sclk_d = 1'b0;
            if (bit_cnt_q != '0) begin
              bit_cnt_d = bit_cnt_q - c_bit_w'(1);
              shreg_d   = {shreg_q[c_bpc-2:0], 1'b0};
              sdata_d   = shreg_q[c_bpc-2];
            end else if (addr_q == '0) begin
              sdata_d = 1'b0;
              latch_d = 1'b1;
              state_d = s_latch;
            end else begin
              addr_d  = addr_q - c_addr_w'(1);
              state_d = s_fetch;
            end
          end
        end
      end

      s_latch: begin
        if (div_cnt_q != c_div_max) begin
          div_cnt_d = div_cnt_q + c_div_w'(1);
        end else begin
          div_cnt_d = '0;
          latch_d   = 1'b0;
          drq_d     = 1'b1;
          state_d   = s_done;
        end
      end

      s_done: begin
        busy_d  = 1'b0;
        state_d = s_idle;
      end

      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (!i_rst_n) begin
      state_q   <= s_idle;
      addr_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      drq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      drq_q     <= drq_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_addr  = addr_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_sdata = sdata_q;
  assign bus.o_latch = latch_q;
  assign bus.o_drq   = drq_q;
  assign bus.o_busy  = busy_q;

endmodule
